// File: rtl/gf22_clk_div.sv
// gf22_clk_div
//   Glitch-free integer clock divider. It supports a run-time divisor change
//   through a valid/ready handshake, enable gating that takes effect only at
//   period boundaries, and a test-mode bypass. The only clock is clk_i.
//
//   The clock path has three stages:
//     1. An ICG (latch + AND) gates clk_i for the bypass path.
//     2. A registered divided clock feeds the divided path.
//     3. A mux2, whose select is registered, picks between the two paths.
//
//   Optional build macro: GF22_CLK_DIV_ODD_DUTY_EN
//     Adds a falling-edge flop, clocked through an inverter cell, so that odd
//     divisors get an exact 50% duty cycle.
//
// Ports
//   clk_i        source clock
//   rst_i        asynchronous reset, active high
//   en_i         output enable, sampled only at period boundaries
//   test_mode_i  forces clk_o = clk_i (scan/DFT)
//   div_i        requested divisor (0 and 1 both mean bypass)
//   div_valid_i  divisor change request
//   div_ready_o  high when a divisor change can be accepted
//   div_o        currently active divisor
//   clk_o        divided / gated clock output

module gf22_clk_div #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             test_mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  output logic [DIV_W-1:0] div_o,
  output logic             clk_o
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic             SEL_RST = (DEFAULT_DIV >= 2);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             en_q, en_d;
  logic             sel_q, sel_d;
  logic             dclk_q, dclk_d;
  logic             bypass, bypass_d, wrap;

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    en_d     = en_q;

    bypass = (div_q[DIV_W-1:1] == '0);

    // While disabled the counter is parked at 0, so every cycle counts as a
    // period boundary. That lets enable and a pending divisor apply promptly.
    wrap = bypass || !en_q || (cnt_q == div_q - ONE);

    if (wrap) begin
      cnt_d = '0;
      en_d  = en_i;
      if (pend_v_q) begin
        div_d    = pend_q;
        pend_v_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + ONE;
    end

    // An accept can only happen when nothing is pending, so a request taken
    // on a wrap edge is never applied on that same edge.
    if (div_valid_i && !pend_v_q) begin
      pend_d   = div_i;
      pend_v_d = 1'b1;
    end

    bypass_d = (div_d[DIV_W-1:1] == '0);
    sel_d    = !bypass_d;

    // In bypass the divided flop follows the enable, so both mux inputs are
    // high right after a mode-switching edge.
    dclk_d = en_d && (bypass_d || (cnt_d < (div_d >> 1)));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      div_q    <= DIV_RST;
      pend_v_q <= 1'b0;
      en_q     <= 1'b0;
      sel_q    <= SEL_RST;
      dclk_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_v_q <= pend_v_d;
      en_q     <= en_d;
      sel_q    <= sel_d;
      dclk_q   <= dclk_d;
    end
  end

  // The pending divisor is qualified by pend_v_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    pend_q <= pend_d;
  end

  // Clock-gating cell: the enable is latched while clk_i is low, so the gated
  // clock can never be cut or started mid-pulse. Reset clears it at once.
  logic en_lat;
  logic gclk;

  always_latch begin
    if (rst_i) begin
      en_lat = 1'b0;
    end else if (!clk_i) begin
      en_lat = en_q | test_mode_i;
    end
  end

  assign gclk = clk_i & en_lat;

  logic dclk_out;

`ifdef GF22_CLK_DIV_ODD_DUTY_EN
  // Inverter cell plus a falling-edge flop: a copy of the divided clock
  // delayed by half a cycle. ORing it in stretches the high phase by half a
  // cycle, and this is only done for odd divisors.
  logic clk_n;
  logic dclk_n_q;

  assign clk_n = ~clk_i;

  always_ff @(posedge clk_n or posedge rst_i) begin
    if (rst_i) begin
      dclk_n_q <= 1'b0;
    end else begin
      dclk_n_q <= dclk_q;
    end
  end

  assign dclk_out = dclk_q | (div_q[0] & dclk_n_q);
`else
  assign dclk_out = dclk_q;
`endif

  // Mux cell: test mode forces the (TE-enabled) gated source clock.
  assign clk_o = (sel_q && !test_mode_i) ? dclk_out : gclk;

  assign div_ready_o = !pend_v_q;
  assign div_o       = div_q;

endmodule

// File: tb/tb_gf22_clk_div.sv
module tb_gf22_clk_div;

  localparam int DIV_W = 8;
`ifdef GF22_CLK_DIV_ODD_DUTY_EN
  localparam bit ODD = 1'b1;
`else
  localparam bit ODD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             tm = 1'b0;
  logic             vld = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic             rdy;
  logic [DIV_W-1:0] div_o;
  logic             clk_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gf22_clk_div #(.DIV_W(DIV_W), .DEFAULT_DIV(1)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .test_mode_i (tm),
    .div_i       (div),
    .div_valid_i (vld),
    .div_ready_o (rdy),
    .div_o       (div_o),
    .clk_o       (clk_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fall();
    @(negedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [DIV_W-1:0] obs,
                      input logic [DIV_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset and bypass
    repeat (5) begin
      tick();
      chk1("rst_clk_o", clk_o, 1'b0);
      chkv("rst_div_o", div_o, 8'd1);
      chk1("rst_ready", rdy, 1'b1);
    end
    rst = 1'b0;
    en  = 1'b1;
    tick();
    chk1("byp_en_edge", clk_o, 1'b0);
    tick();
    chk1("byp_hi", clk_o, 1'b1);
    fall();
    chk1("byp_lo", clk_o, 1'b0);
    tick();
    chk1("byp_hi2", clk_o, 1'b1);
    chkv("byp_div_o", div_o, 8'd1);
    chk1("byp_ready", rdy, 1'b1);

    // Even divide by 4
    div = 8'd4;
    vld = 1'b1;
    tick();
    chk1("div4_ready_low", rdy, 1'b0);
    chkv("div4_div_o_old", div_o, 8'd1);
    vld = 1'b0;
    tick();
    chk1("div4_ready_back", rdy, 1'b1);
    chkv("div4_div_o", div_o, 8'd4);
    for (int i = 0; i < 8; i++) begin
      chk1("div4_pos", clk_o, (i % 4) < 2);
      fall();
      chk1("div4_neg", clk_o, (i % 4) < 2);
      tick();
    end

    // Odd divide by 5
    div = 8'd5;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    chk1("div5_ready_low", rdy, 1'b0);
    chk1("div5_old_c1", clk_o, 1'b1);
    tick();
    chk1("div5_old_c2", clk_o, 1'b0);
    tick();
    chk1("div5_old_c3", clk_o, 1'b0);
    chkv("div5_div_o_old", div_o, 8'd4);
    tick();
    chkv("div5_div_o", div_o, 8'd5);
    chk1("div5_ready_back", rdy, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk1("div5_pos", clk_o, ((i % 5) < 2) || (ODD && (i % 5) == 2));
      fall();
      chk1("div5_neg", clk_o, (i % 5) < 2);
      tick();
    end

    // Change requested exactly on the wrap cycle
    div = 8'd6;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    repeat (4) tick();
    chkv("div6_div_o", div_o, 8'd6);
    repeat (5) tick();
    chk1("div6_c5_low", clk_o, 1'b0);
    div = 8'd3;
    vld = 1'b1;
    tick();
    div = 8'd7;
    chk1("wrap_acc_ready", rdy, 1'b0);
    chkv("wrap_acc_div_o", div_o, 8'd6);
    for (int i = 0; i < 6; i++) begin
      chk1("div6_extra_period", clk_o, i < 3);
      chkv("div6_still", div_o, 8'd6);
      tick();
    end
    vld = 1'b0;
    chkv("div3_applied", div_o, 8'd3);
    chk1("div3_ready", rdy, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk1("div3_pos", clk_o, ((i % 3) < 1) || (ODD && (i % 3) == 1));
      tick();
    end
    chkv("div7_ignored", div_o, 8'd3);

    // Enable at D = 8
    div = 8'd8;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    tick();
    tick();
    chkv("div8_div_o", div_o, 8'd8);
    repeat (3) tick();
    en = 1'b0;
    chk1("dis_c3_hi", clk_o, 1'b1);
    for (int i = 4; i < 8; i++) begin
      tick();
      chk1("dis_period_completes", clk_o, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      chk1("dis_pos", clk_o, 1'b0);
      fall();
      chk1("dis_neg", clk_o, 1'b0);
    end
    en = 1'b1;
    tick();
    chk1("reen_first_hi", clk_o, 1'b1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk1("reen_period", clk_o, i < 4);
    end
    tick();

    // Reset mid-period with a pending divisor
    div = 8'd2;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    tick();
    tick();
    chk1("mid_c3_hi", clk_o, 1'b1);
    chk1("mid_pending", rdy, 1'b0);
    rst = 1'b1;
    #1;
    chk1("mid_rst_clk_o", clk_o, 1'b0);
    chkv("mid_rst_div_o", div_o, 8'd1);
    chk1("mid_rst_ready", rdy, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk1("post_rst_hi", clk_o, 1'b1);
    fall();
    chk1("post_rst_lo", clk_o, 1'b0);
    tick();
    tick();
    chkv("pend_lost", div_o, 8'd1);

    // Test mode overrides a disabled output
    en = 1'b0;
    tick();
    fall();
    tick();
    chk1("tm_pre_disabled", clk_o, 1'b0);
    tm = 1'b1;
    fall();
    chk1("tm_lo", clk_o, 1'b0);
    tick();
    chk1("tm_hi", clk_o, 1'b1);
    fall();
    chk1("tm_lo2", clk_o, 1'b0);
    tick();
    chk1("tm_hi2", clk_o, 1'b1);
    tm = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
